// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - two-operand capture from a shared switch bank via one debounced load button
// Press sequence walks LOAD_A -> LOAD_B -> SHOW -> LOAD_A; clr_n forces everything back to LOAD_A.
module operand_entry #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       key_n,
    input  logic       clr_n,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       valid,
    output logic [1:0] phase
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        SHOW   = 2'b10
    } state_t;

    logic [3:0]    r_sw_meta, r_sw_sync;
    logic          r_key_meta, r_key_sync;
    logic          r_clr_meta, r_clr_sync;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_press;
    logic [3:0]    r_a, r_b;
    state_t        r_state, w_next_state;
    logic          w_mismatch, w_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_meta  <= 4'd0;
            r_sw_sync  <= 4'd0;
            r_key_meta <= 1'b1;
            r_key_sync <= 1'b1;
            r_clr_meta <= 1'b1;
            r_clr_sync <= 1'b1;
        end else begin
            r_sw_meta  <= sw;
            r_sw_sync  <= r_sw_meta;
            r_key_meta <= key_n;
            r_key_sync <= r_key_meta;
            r_clr_meta <= clr_n;
            r_clr_sync <= r_clr_meta;
        end
    end

    assign w_mismatch = (r_key_sync != r_stable);
    assign w_accept   = w_mismatch && (r_cnt == CNT_MAX);

    // Accepting a new level while the old one was high is the only press event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable <= 1'b1;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_press <= w_accept && r_stable;
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_key_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (!r_clr_sync) begin
            w_next_state = LOAD_A;
        end else if (r_press) begin
            case (r_state)
                LOAD_A:  w_next_state = LOAD_B;
                LOAD_B:  w_next_state = SHOW;
                default: w_next_state = LOAD_A;
            endcase
        end
    end

    // Clear wins over a coincident press, so the operand loads are gated by it too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= 4'd0;
            r_b <= 4'd0;
        end else if (!r_clr_sync) begin
            r_a <= 4'd0;
            r_b <= 4'd0;
        end else if (r_press) begin
            if (r_state == LOAD_A) r_a <= r_sw_sync;
            if (r_state == LOAD_B) r_b <= r_sw_sync;
        end
    end

    always_comb begin
        A     = r_a;
        B     = r_b;
        valid = (r_state == SHOW);
        phase = r_state;
    end

endmodule

// File: tb/tb_operand_entry.sv
// tb/tb_operand_entry.sv - vector-table and sequence bench for operand_entry with DEBOUNCE_CYCLES=4
module tb_operand_entry;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw;
    logic       key_n;
    logic       clr_n;
    logic [3:0] A;
    logic [3:0] B;
    logic       valid;
    logic [1:0] phase;

    int total;
    int bad;

    operand_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw),
        .key_n (key_n),
        .clr_n (clr_n),
        .A     (A),
        .B     (B),
        .valid (valid),
        .phase (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sw;
        int         hold;
        logic [3:0] a;
        logic [3:0] b;
        logic       v;
        logic [1:0] ph;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [3:0] ea, input logic [3:0] eb,
                       input logic ev, input logic [1:0] eph);
        total++;
        if ({A, B, valid, phase} !== {ea, eb, ev, eph}) begin
            bad++;
            $display("FAIL %s: got A=%0d B=%0d valid=%0d phase=%0d, want A=%0d B=%0d valid=%0d phase=%0d",
                     nm, A, B, valid, phase, ea, eb, ev, eph);
        end
    endtask

    task automatic press(input logic [3:0] s, input int hold);
        sw    = s;
        key_n = 1'b0;
        repeat (hold) @(negedge clk);
        key_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = '{sw: 4'd3,  hold: 10,  a: 4'd4,  b: 4'd3,  v: 1'b1, ph: 2'd2};
        vecs[1] = '{sw: 4'd7,  hold: 10,  a: 4'd4,  b: 4'd3,  v: 1'b0, ph: 2'd0};
        vecs[2] = '{sw: 4'd9,  hold: 100, a: 4'd9,  b: 4'd3,  v: 1'b0, ph: 2'd1};
        vecs[3] = '{sw: 4'd15, hold: 10,  a: 4'd9,  b: 4'd15, v: 1'b1, ph: 2'd2};
        vecs[4] = '{sw: 4'd0,  hold: 10,  a: 4'd9,  b: 4'd15, v: 1'b0, ph: 2'd0};
        vecs[5] = '{sw: 4'd15, hold: 10,  a: 4'd15, b: 4'd15, v: 1'b0, ph: 2'd1};
        vecs[6] = '{sw: 4'd15, hold: 10,  a: 4'd15, b: 4'd15, v: 1'b1, ph: 2'd2};

        rst_n = 1'b1;
        key_n = 1'b1;
        clr_n = 1'b1;
        sw    = 4'd0;
        #1;
        rst_n = 1'b0;
        sw    = 4'($urandom);
        key_n = 1'($urandom);
        clr_n = 1'($urandom);
        #2;
        chk("reset_async", 4'd0, 4'd0, 1'b0, 2'd0);
        repeat (3) @(negedge clk);
        key_n = 1'b1;
        clr_n = 1'b1;
        sw    = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            repeat (5) @(negedge clk);
            chk("post_reset_idle", 4'd0, 4'd0, 1'b0, 2'd0);
        end

        sw    = 4'd4;
        key_n = 1'b0;
        repeat (6) @(negedge clk);
        chk("load_a_edge6", 4'd0, 4'd0, 1'b0, 2'd0);
        @(negedge clk);
        chk("load_a_edge7", 4'd4, 4'd0, 1'b0, 2'd1);
        repeat (3) @(negedge clk);
        key_n = 1'b1;
        repeat (12) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            press(vecs[i].sw, vecs[i].hold);
            chk($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].v, vecs[i].ph);
        end

        sw    = 4'd2;
        key_n = 1'b0;
        repeat (4) @(negedge clk);
        clr_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("clear_priority", 4'd0, 4'd0, 1'b0, 2'd0);
        repeat (5) @(negedge clk);
        chk("clear_hold", 4'd0, 4'd0, 1'b0, 2'd0);
        key_n = 1'b1;
        repeat (12) @(negedge clk);
        clr_n = 1'b1;
        repeat (3) @(negedge clk);
        press(4'd5, 10);
        chk("after_clear_load_a", 4'd5, 4'd0, 1'b0, 2'd1);

        key_n = 1'b0;
        repeat (3) @(negedge clk);
        key_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("glitch_3_cycles", 4'd5, 4'd0, 1'b0, 2'd1);

        sw = 4'd8;
        for (int i = 0; i < 10; i++) begin
            key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) @(negedge clk);
        end
        key_n = 1'b0;
        repeat (6) @(negedge clk);
        chk("toggle_edge6", 4'd5, 4'd0, 1'b0, 2'd1);
        @(negedge clk);
        chk("toggle_edge7", 4'd5, 4'd8, 1'b1, 2'd2);
        repeat (30) @(negedge clk);
        chk("toggle_one_event", 4'd5, 4'd8, 1'b1, 2'd2);
        key_n = 1'b1;
        repeat (12) @(negedge clk);

        sw    = 4'd6;
        key_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_count", 4'd0, 4'd0, 1'b0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_release_edge6", 4'd0, 4'd0, 1'b0, 2'd0);
        @(negedge clk);
        chk("rst_release_edge7", 4'd6, 4'd0, 1'b0, 2'd1);
        key_n = 1'b1;
        repeat (12) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_entry.md
# operand_entry

Captures the two 4-bit operands for the BCD adder/display stage from a shared 4-bit switch bank using one push-button. Each debounced press latches the switches into A, then into B. The block then presents both operands with a valid flag. It sits directly upstream of the adder, whose A/B inputs are driven from this block's A/B outputs.

## Interface
- DEBOUNCE_CYCLES, 500000, number of consecutive cycles the synchronized button level must differ from the accepted level before it is accepted (10 ms at 50 MHz). Must be ≥2. The counter width is $clog2(DEBOUNCE_CYCLES).
- clk  in  1  system clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- sw  in  4  operand switches, asynchronous to clk
- key_n  in  1  load push-button, active-low, asynchronous, bouncy
- clr_n  in  1  clear push-button, active-low, asynchronous
- A  out  4  operand A to adder
- B  out  4  operand B to adder
- valid  out  1  high while A and B are both loaded (SHOW phase)
- phase  out  2  current state for LEDs: 00 LOAD_A, 01 LOAD_B, 10 SHOW (11 never driven)

## Operation
- Synchronizers: sw, key_n and clr_n each pass through a 2-flop synchronizer. On reset, the key_n and clr_n synchronizers load 1 and the sw synchronizer loads 0.
- Debouncer on the synchronized key_n:
  - Holds an accepted level `stable` (reset 1) and a counter (reset 0).
  - On any cycle where the synchronized level equals `stable`, the counter clears to 0.
  - On a mismatch, the counter increments.
  - On a mismatch with the counter at DEBOUNCE_CYCLES-1, `stable` takes the synchronized level and the counter clears.
- Press event: a registered 1-cycle pulse, asserted on the edge where `stable` goes 1→0. Release (0→1) generates no event.
- FSM states are LOAD_A, LOAD_B and SHOW. It acts on the press pulse and samples the synchronized sw:
  - LOAD_A + press: A ← sw, go to LOAD_B.
  - LOAD_B + press: B ← sw, go to SHOW, valid ← 1.
  - SHOW + press: go to LOAD_A, valid ← 0. A and B hold until overwritten.
  - With no press, the state and registers hold.
- Clear (synchronized clr_n low, level-acting, not debounced):
  - A ← 0, B ← 0, valid ← 0, state ← LOAD_A.
  - Clear overrides a simultaneous press pulse; that press is discarded.
  - The debouncer keeps running during clear.
- Reset values: A=0, B=0, valid=0, phase=00, `stable`=1, counter=0, press pulse=0.
- Width rules:
  - A and B are raw 4-bit copies of sw; no range check is made, so values 10–15 pass through unchanged.
  - The counter saturates by design: it never exceeds DEBOUNCE_CYCLES-1.

## Timing
- Edge numbering: edge 1 is the first rising edge that samples key_n low.
  - The synchronized level goes low after edge 2.
  - The counter increments on edges 3..DEBOUNCE_CYCLES+1.
  - `stable` flips and the press pulse asserts on edge DEBOUNCE_CYCLES+2.
  - A/B/state/valid/phase update on edge DEBOUNCE_CYCLES+3.
- Glitch rejection: if key_n returns high and the synchronized level matches `stable` for even one cycle before acceptance, the counter clears and no event occurs.
- One event per physical press: a held button produces exactly one pulse. A new event requires a debounced release followed by a debounced press.
- Switch setup: sw must be stable at least 2 cycles before the FSM update edge (edge DEBOUNCE_CYCLES+3); the value in the sw synchronizer output at that edge is latched.
- Clear latency: the outputs clear on the 3rd edge after clr_n is first sampled low, and remain cleared while clr_n stays low.
- Asynchronous reset: assertion of rst_n forces all reset values immediately, mid-count or mid-FSM. A button held through the reset release is seen as a fresh press after DEBOUNCE_CYCLES+3 edges.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset check: hold rst_n low with random inputs → A=0, B=0, valid=0, phase=00 without a clock edge. After release with key_n=1, the outputs are unchanged for 20 cycles.
- Full load sequence:
  - sw=4, press key_n for 10 cycles → A=4 and phase=01 exactly at edge 7. Release.
  - sw=3, press again → B=3, valid=1, phase=10.
  - Third press → phase=00, valid=0, A=4, B=3 held.
- Bounce rejection:
  - key_n low for 3 cycles, then high → no change.
  - Toggle key_n every 2 cycles for 20 cycles, then hold low → exactly one event, occurring 7 edges after the final falling sample.
- Held button: key_n low for 100 cycles in LOAD_A with sw=9 → only A=9 and phase=01; B is not loaded.
- Clear priority:
  - In SHOW with A=15, B=15, assert clr_n low so that its synchronized low coincides with the press-pulse cycle → A=0, B=0, phase=00; the press is ignored.
  - After clr_n high, the next press loads A.
- Mid-debounce reset: assert rst_n at counter=2 while key_n is held low, then release → the press is accepted 7 edges after release, with no early event.
